// File: rtl/serial_word_deser_pkg.sv
// serial_word_deser_pkg: shared types and defaults for the serial word deserializer.
// The optional parity feature is selected with the DESER_PARITY_EN macro.
package serial_word_deser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_word_deser_if.sv
// serial_word_deser_if: serial bit stream in, word valid/ready handshake out.
// The master side is the stream source and word consumer; the slave side is the deserializer.
interface serial_word_deser_if
  import serial_word_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             bit_en;
  logic             start;
  logic             din;
  logic             ovf_in;
  logic [WIDTH-1:0] word;
  logic             word_ovf;
  logic             word_perr;
  logic             word_valid;
  logic             word_ready;
  logic             frame_err;
  logic             overrun;

  modport master (
    output bit_en, start, din, ovf_in, word_ready,
    input  word, word_ovf, word_perr, word_valid, frame_err, overrun
  );

  modport slave (
    input  bit_en, start, din, ovf_in, word_ready,
    output word, word_ovf, word_perr, word_valid, frame_err, overrun
  );

endinterface

// File: rtl/serial_word_deser_shift_reg.sv
// deser_shift_reg: WIDTH-bit indexed-load word register with overflow and parity accumulators.
// load starts a new frame at bit 0, wr stores a data bit at idx, acc folds in a parity-only bit.
module deser_shift_reg
  import serial_word_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             wr,
  input  logic             acc,
  input  logic             din,
  input  logic             ovf_in,
  input  logic [CW-1:0]    idx,
  output logic [WIDTH-1:0] data,
  output logic             ovf,
  output logic             par
);

  // Word assembly: clear-and-load on frame start, indexed store per data bit, accumulate flags.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: the data register is reset because it drives the word output directly, which must read 0 out of reset.
    if (!reset) begin
      data <= '0;
      ovf  <= 1'b0;
      par  <= 1'b0;
    end else if (load) begin
      data <= WIDTH'(din);
      ovf  <= ovf_in;
      par  <= din;
    end else if (wr) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (idx == CW'(i)) data[i] <= din;
      end
      ovf <= ovf | ovf_in;
      par <= par ^ din;
    end else if (acc) begin
      ovf <= ovf | ovf_in;
      par <= par ^ din;
    end
  end

endmodule

// File: rtl/serial_word_deser.sv
// serial_word_deser: LSB-first serial-to-word deserializer with valid/ready output,
// framing-error pulse and sticky overrun flag. Define DESER_PARITY_EN to add an even
// parity bit per frame (state PAR) and drive word_perr; otherwise word_perr is 0.
module serial_word_deser
  import serial_word_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clock,
  input logic              reset,
  serial_word_deser_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] count;
  logic          valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  logic             qual_start;
  logic             qual_data;
  logic             load;
  logic             wr;
  logic             acc;
  logic [WIDTH-1:0] sr_data;
  logic             sr_ovf;
  logic             sr_par;

  // Shift-register controls decoded from the current state and qualified inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    qual_start = bus.bit_en && bus.start;
    qual_data  = bus.bit_en && !bus.start;
    load       = qual_start && ((state != HOLD) || bus.word_ready);
    wr         = qual_data && (state == SHIFT);
    acc        = PAR_EN && qual_data && (state == PAR);
  end

  deser_shift_reg #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shift_reg (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .wr     (wr),
    .acc    (acc),
    .din    (bus.din),
    .ovf_in (bus.ovf_in),
    .idx    (count),
    .data   (sr_data),
    .ovf    (sr_ovf),
    .par    (sr_par)
  );

  // Frame FSM with registered handshake and error outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only here; the default below is overridden later in the same block.
      frame_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (qual_start) begin
            state <= SHIFT;
            count <= CW'(1);
          end
        end
        SHIFT, PAR: begin
          if (qual_start) begin
            // Restart: partial word is discarded, this bit is bit 0 of the new frame.
            frame_err_q <= 1'b1;
            state       <= SHIFT;
            count       <= CW'(1);
          end else if (qual_data) begin
            if (state == PAR) begin
              state   <= HOLD;
              valid_q <= 1'b1;
            end else begin
              count <= count + CW'(1);
              if (count == LAST) begin
                state   <= PAR_EN ? PAR : HOLD;
                valid_q <= !PAR_EN;
              end
            end
          end
        end
        HOLD: begin
          if (bus.word_ready) begin
            valid_q <= 1'b0;
            if (qual_start) begin
              state <= SHIFT;
              count <= CW'(1);
            end else begin
              state <= IDLE;
              count <= '0;
            end
          end else if (qual_start) begin
            overrun_q   <= 1'b1;
            frame_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.word       = sr_data;
  assign bus.word_ovf   = sr_ovf;
  assign bus.word_perr  = PAR_EN && sr_par;
  assign bus.word_valid = valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_serial_word_deser.sv
// tb_serial_word_deser: scoreboard bench for serial_word_deser (WIDTH=8).
// Builds with or without DESER_PARITY_EN; parity vectors are only sent when it is defined.
module tb_serial_word_deser;

  typedef struct packed {
    logic [7:0] w;
    logic       o;
    logic       p;
  } exp_t;

  logic clock;
  logic rst_n;
  int   checks;
  int   errors;
  int   fe_cnt;
  exp_t sb[$];

  serial_word_deser_if #(.WIDTH(8)) bus ();

  serial_word_deser #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted word against the scoreboard head, counts frame_err pulses.
  always @(negedge clock) begin
    if (rst_n) begin
      if (bus.frame_err) fe_cnt++;
      if (bus.word_valid && bus.word_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h with empty scoreboard", bus.word);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word", 32'(bus.word), 32'(e.w));
          check("word_ovf", 32'(bus.word_ovf), 32'(e.o));
          check("word_perr", 32'(bus.word_perr), 32'(e.p));
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One qualified bit, sampled at the next rising edge.
  task automatic drive_bit(input logic st, input logic d, input logic o);
    bus.bit_en = 1'b1;
    bus.start  = st;
    bus.din    = d;
    bus.ovf_in = o;
    @(posedge clock);
    #1;
    bus.bit_en = 1'b0;
    bus.start  = 1'b0;
    bus.din    = 1'b0;
    bus.ovf_in = 1'b0;
  endtask

  // Full frame, LSB first; pbit is the parity bit when parity is compiled in.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] om, input logic pbit,
                            input bit expect_word);
    exp_t e;
    e.w = d;
    e.o = |om;
`ifdef DESER_PARITY_EN
    e.p = (^d) ^ pbit;
`else
    e.p = 1'b0;
`endif
    if (expect_word) sb.push_back(e);
    for (int i = 0; i < 8; i++) drive_bit(i == 0, d[i], om[i]);
`ifdef DESER_PARITY_EN
    drive_bit(1'b0, pbit, 1'b0);
`endif
  endtask

  initial begin
    int fe_before;
    checks = 0;
    errors = 0;
    fe_cnt = 0;
    rst_n          = 1'b0;
    bus.bit_en     = 1'b0;
    bus.start      = 1'b0;
    bus.din        = 1'b0;
    bus.ovf_in     = 1'b0;
    bus.word_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_word", 32'(bus.word), 32'h0);
    check("rst_word_ovf", 32'(bus.word_ovf), 32'h0);
    check("rst_word_perr", 32'(bus.word_perr), 32'h0);
    check("rst_word_valid", 32'(bus.word_valid), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // Basic frame 1,0,1,1,0,0,1,0 -> 0x4D; valid for exactly one cycle with ready high.
    send_frame(8'h4D, 8'h00, 1'b0, 1'b1);
    check("valid_first_cycle", 32'(bus.word_valid), 32'h1);
    idle_cycles(1);
    check("valid_second_cycle", 32'(bus.word_valid), 32'h0);
    idle_cycles(2);

    // ovf_in only on bit 5.
    send_frame(8'h4D, 8'h20, 1'b0, 1'b1);
    idle_cycles(3);

    // Start re-asserted on bit 4, then a full 0xFF frame.
    fe_before = fe_cnt;
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 8'h00, 1'b0, 1'b1);
    idle_cycles(3);
    check("restart_frame_err_pulses", 32'(fe_cnt - fe_before), 32'd1);

    // Back-to-back frames with ready high: the second start lands in the first HOLD cycle.
    send_frame(8'hA5, 8'h00, 1'b0, 1'b1);
    send_frame(8'h0F, 8'h01, 1'b1, 1'b1);
    idle_cycles(3);
    check("coincident_overrun", 32'(bus.overrun), 32'h0);

    // Overrun: consumer stalls, a new frame arrives and is dropped.
    bus.word_ready = 1'b0;
    fe_before = fe_cnt;
    send_frame(8'h5A, 8'h00, 1'b0, 1'b1);
    idle_cycles(1);
    send_frame(8'hC3, 8'h00, 1'b0, 1'b0);
    idle_cycles(1);
    check("overrun_set", 32'(bus.overrun), 32'h1);
    check("overrun_frame_err", 32'(fe_cnt - fe_before), 32'd1);
    check("overrun_valid_held", 32'(bus.word_valid), 32'h1);
    check("overrun_word_held", 32'(bus.word), 32'h5A);
    bus.word_ready = 1'b1;
    idle_cycles(2);
    send_frame(8'h3C, 8'h00, 1'b1, 1'b1);
    idle_cycles(3);
    check("overrun_sticky", 32'(bus.overrun), 32'h1);

`ifdef DESER_PARITY_EN
    // Parity: 0x03 with parity bit 1 -> error; with 0 -> clean.
    send_frame(8'h03, 8'h00, 1'b1, 1'b1);
    idle_cycles(2);
    send_frame(8'h03, 8'h00, 1'b0, 1'b1);
    idle_cycles(3);
`endif

    // Reset in mid-frame, then a clean frame.
    drive_bit(1'b1, 1'b1, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_word", 32'(bus.word), 32'h0);
    check("midrst_word_ovf", 32'(bus.word_ovf), 32'h0);
    check("midrst_word_valid", 32'(bus.word_valid), 32'h0);
    check("midrst_overrun", 32'(bus.overrun), 32'h0);
    check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
    check("midrst_word_perr", 32'(bus.word_perr), 32'h0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    idle_cycles(1);
    send_frame(8'h96, 8'h00, 1'b0, 1'b1);
    idle_cycles(4);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_deser.md
# serial_word_deser

- Downstream consumer of the bit-serial comparator FSM's `outp`/`overflw` stream.
- Shifts qualified serial bits LSB-first into a WIDTH-bit word and tracks whether `overflw` was seen during the frame.
- Presents each completed word on a valid/ready handshake to the word-level checker.
- Flags framing errors and overruns.

## Interface
Parameters:
- WIDTH, 8, data bits per frame (2..32)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- bit_en  in  1  qualifies `din`/`ovf_in`/`start` this cycle
- start  in  1  with `bit_en`: current `din` is bit 0 of a new frame
- din  in  1  serial data (upstream `outp`)
- ovf_in  in  1  upstream `overflw`, sampled on every qualified bit
- word  out  WIDTH  assembled word, bit 0 = first bit received
- word_ovf  out  1  1 if `ovf_in` was 1 on any qualified bit of this frame
- word_perr  out  1  parity error for this word (only when DESER_PARITY_EN is defined; otherwise constant 0)
- word_valid  out  1  word/word_ovf/word_perr valid; held until accepted
- word_ready  in  1  consumer accepts when `word_valid && word_ready`
- frame_err  out  1  one-cycle pulse: frame restarted or aborted
- overrun  out  1  sticky; a frame start was lost while HOLD; cleared only by reset

## Operation
- States: IDLE, SHIFT, (PAR when DESER_PARITY_EN), HOLD.
- Reset value of every output is 0; state IDLE, bit counter 0.
- IDLE:
  - `bit_en && start`: load `din` to bit 0, load `ovf_in` into the ovf accumulator, count=1, go to SHIFT.
  - `bit_en && !start`: ignored.
- SHIFT:
  - Each `bit_en` with `!start` stores `din` at bit[count] and ORs in `ovf_in`; count increments.
  - On the qualified bit where count reaches WIDTH-1 (last data bit): go to HOLD, or to PAR when parity is compiled in.
  - Cycles without `bit_en`: hold state and count, no timeout.
- Start mid-frame (SHIFT or PAR, `bit_en && start`):
  - Pulse `frame_err`, discard the partial word.
  - Treat the bit as bit 0 of a new frame: count=1, state SHIFT.
- HOLD:
  - `word_valid`=1; `word`, `word_ovf`, `word_perr` stable.
  - `word_ready`=1: handshake; next state IDLE, `word_valid` falls next cycle.
  - `bit_en && start` with `word_ready`=1 in the same cycle: handshake completes AND the bit loads as bit 0 of a new frame (state SHIFT, no loss).
  - `bit_en && start` with `word_ready`=0: bit dropped, `overrun` set, `frame_err` pulses; stay HOLD.
  - `bit_en && !start` in HOLD: ignored silently.
- Counter width is $clog2(WIDTH+1) and never wraps.
- Asynchronous reset mid-frame or in HOLD: pending word is lost, no handshake.

## Timing
- Word available one cycle after its last qualified bit: the cycle after the last bit with WIDTH data bits, or after the parity bit when parity is compiled in.
- Minimum frame-to-frame throughput:
  - WIDTH (or WIDTH+1) qualified bits per word.
  - Zero bubbles when `word_ready` is tied high and the next start arrives in the first HOLD cycle.
- `frame_err` is asserted for exactly the cycle after the offending bit.
- `overrun` rises in the cycle after the dropped start.
- No combinational path from inputs to outputs.

## Configuration
- `DESER_PARITY_EN` defined:
  - Each frame carries one extra qualified bit after the WIDTH data bits, handled in state PAR.
  - `word_perr` = XOR(word bits, parity bit) (even parity).
  - `ovf_in` is also ORed on the parity bit.
- Not defined: PAR state and parity logic are absent, frames are WIDTH bits, `word_perr` is tied 0.

## Structure
- `serial_word_deser_pkg`: state enum (IDLE, SHIFT, PAR, HOLD) and the default WIDTH constant.
- One sub-module, `deser_shift_reg`: WIDTH-bit indexed-load register with clear and ovf/parity accumulators.
- The FSM and handshake live in the top.

## Test plan
- WIDTH=8, ready high, bits 1,0,1,1,0,0,1,0 with start on the first bit, `ovf_in`=0 -> `word`=8'h4D, `word_ovf`=0, `word_valid` for one cycle.
- Same frame with `ovf_in`=1 only on bit 5 -> `word`=8'h4D, `word_ovf`=1.
- Start re-asserted on bit 4 of a frame, then 8 bits of 8'hFF -> `frame_err` pulses once, `word`=8'hFF.
- `word_ready`=0 and a new start while in HOLD -> `overrun`=1 sticky, old word unchanged until ready, then the next valid frame is delivered normally.
- `word_ready`=1 coincident with a new start in HOLD -> both words delivered, `overrun` stays 0.
- With `DESER_PARITY_EN`: data 8'h03 plus parity bit 1 -> `word_perr`=1; with parity bit 0 -> `word_perr`=0.
- Reset (low) in mid-frame -> all outputs 0 and the next frame decodes correctly.
